// File: rtl/frac_pixel_dispatch_if.sv
`default_nettype none
// ============================================================================
//  Module   : frac_pixel_dispatch_if
//  Purpose  : Bundles the dispatcher's frame-request, fractal-core and
//             pixel-write signals. Optional: FRAC_DISPATCH_WDOG_EN adds wdog_err.
//  Revision : 1.0  initial release
// ============================================================================
interface frac_pixel_dispatch_if #(
    parameter int N  = 32,
    parameter int AW = 19
);
    logic          start;
    logic [N-1:0]  x0;
    logic [N-1:0]  y0;
    logic [N-1:0]  dx;
    logic [N-1:0]  dy;
    logic [15:0]   max_iter;
    logic          busy;
    logic          frame_done;
    logic [N-1:0]  frac_cx;
    logic [N-1:0]  frac_cy;
    logic [15:0]   frac_max_iter;
    logic          frac_go;
    logic          frac_busy;
    logic          frac_done_tick;
    logic          frac_found;
    logic [AW-1:0] pix_addr;
    logic          pix_data;
    logic          pix_valid;
    logic          pix_ready;
`ifdef FRAC_DISPATCH_WDOG_EN
    logic          wdog_err;
`endif

    modport master (
        input  start, x0, y0, dx, dy, max_iter,
        input  frac_busy, frac_done_tick, frac_found, pix_ready,
        output busy, frame_done, frac_cx, frac_cy, frac_max_iter, frac_go,
        output pix_addr, pix_data, pix_valid
`ifdef FRAC_DISPATCH_WDOG_EN
        , output wdog_err
`endif
    );

    modport slave (
        output start, x0, y0, dx, dy, max_iter,
        output frac_busy, frac_done_tick, frac_found, pix_ready,
        input  busy, frame_done, frac_cx, frac_cy, frac_max_iter, frac_go,
        input  pix_addr, pix_data, pix_valid
`ifdef FRAC_DISPATCH_WDOG_EN
        , input wdog_err
`endif
    );
endinterface
`default_nettype wire

// File: rtl/frac_pixel_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : frac_pixel_dispatch
//  Purpose  : Sweeps a pixel window, launches one fractal evaluation per pixel
//             and writes each result out. Optional: FRAC_DISPATCH_WDOG_EN.
//  Revision : 1.0  initial release
// ============================================================================
module frac_pixel_dispatch #(
    parameter int N        = 32,
    parameter int M        = 4,
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int AW       = 19,
    parameter int WDOG_CYC = 65535
) (
    input  logic                  frac_clk,
    input  logic                  frac_rst_n,
    frac_pixel_dispatch_if.master bus
);
    localparam int CW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int RW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [CW-1:0] C_COL_LAST = CW'(H_RES - 1);
    localparam logic [RW-1:0] C_ROW_LAST = RW'(V_RES - 1);
    localparam bit C_CFG_OK = (M < N) && (WDOG_CYC > 0) &&
                              ((64'd1 << AW) >= (64'(H_RES) * 64'(V_RES)));

    if (!C_CFG_OK) begin : g_cfg_error
        $error("frac_pixel_dispatch: inconsistent parameters");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t        state_q;
    logic [N-1:0]  x0_q, dx_q, dy_q;
    logic [N-1:0]  cx_q, cy_q, cx_d, cy_d;
    logic [15:0]   max_iter_q;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [AW-1:0] addr_q;
    logic          busy_q, done_q, go_q, valid_q, data_q;
    logic          w_last;

    assign w_last = (col_q == C_COL_LAST) && (row_q == C_ROW_LAST);

    // Raster advance; column wrap reloads cx from the latched origin
    always_comb begin
        cx_d  = cx_q + dx_q;
        cy_d  = cy_q;
        col_d = col_q + CW'(1);
        row_d = row_q;
        if (col_q == C_COL_LAST) begin
            cx_d  = x0_q;
            col_d = '0;
            row_d = row_q + RW'(1);
            cy_d  = cy_q + dy_q;
        end
    end

`ifdef FRAC_DISPATCH_WDOG_EN
    localparam int WW = $clog2(WDOG_CYC + 1);
    localparam logic [WW-1:0] C_WDOG_LIM = WW'(WDOG_CYC);
    logic [WW-1:0] wdog_q;
    logic          wdog_err_q;
    assign bus.wdog_err = wdog_err_q;
`endif

    always_ff @(posedge frac_clk or negedge frac_rst_n) begin
        if (!frac_rst_n) begin
            state_q    <= S_IDLE;
            x0_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            max_iter_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            go_q       <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= 1'b0;
`ifdef FRAC_DISPATCH_WDOG_EN
            wdog_q     <= '0;
            wdog_err_q <= 1'b0;
`endif
        end else begin
            go_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        x0_q       <= bus.x0;
                        dx_q       <= bus.dx;
                        dy_q       <= bus.dy;
                        cx_q       <= bus.x0;
                        cy_q       <= bus.y0;
                        max_iter_q <= bus.max_iter;
                        col_q      <= '0;
                        row_q      <= '0;
                        addr_q     <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!bus.frac_busy) begin
                        go_q    <= 1'b1;
                        state_q <= S_WAIT;
`ifdef FRAC_DISPATCH_WDOG_EN
                        wdog_q  <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (bus.frac_done_tick) begin
                        data_q  <= bus.frac_found;
                        valid_q <= 1'b1;
                        state_q <= S_WRITE;
                    end
`ifdef FRAC_DISPATCH_WDOG_EN
                    else if (wdog_q == C_WDOG_LIM) begin
                        data_q     <= 1'b0;
                        valid_q    <= 1'b1;
                        wdog_err_q <= 1'b1;
                        state_q    <= S_WRITE;
                    end else begin
                        wdog_q <= wdog_q + WW'(1);
                    end
`endif
                end
                S_WRITE: begin
                    if (bus.pix_ready) begin
                        valid_q <= 1'b0;
                        if (w_last) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            cx_q    <= cx_d;
                            cy_q    <= cy_d;
                            col_q   <= col_d;
                            row_q   <= row_d;
                            addr_q  <= addr_q + AW'(1);
                            state_q <= S_ISSUE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.frame_done    = done_q;
    assign bus.frac_cx       = cx_q;
    assign bus.frac_cy       = cy_q;
    assign bus.frac_max_iter = max_iter_q;
    assign bus.frac_go       = go_q;
    assign bus.pix_addr      = addr_q;
    assign bus.pix_data      = data_q;
    assign bus.pix_valid     = valid_q;
endmodule
`default_nettype wire

// File: tb/tb_frac_pixel_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frac_pixel_dispatch
//  Purpose  : Self-checking bench for frac_pixel_dispatch on a 4x2 window with
//             a cycle-driven core model. Optional: FRAC_DISPATCH_WDOG_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frac_pixel_dispatch;
    localparam int C_N = 32, C_M = 4, C_H = 4, C_V = 2, C_AW = 3, C_WDOG = 10;
    localparam int C_PIX = C_H * C_V;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] x0_v, y0_v, dx_v, dy_v;
    logic [15:0] mi_v;

    frac_pixel_dispatch_if #(.N(C_N), .AW(C_AW)) bus ();

    frac_pixel_dispatch #(
        .N(C_N), .M(C_M), .H_RES(C_H), .V_RES(C_V), .AW(C_AW), .WDOG_CYC(C_WDOG)
    ) dut (
        .frac_clk  (clk),
        .frac_rst_n(rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Reference coordinates: origin plus column/row multiples of the step
    function automatic logic [31:0] m_cx(input int i);
        return x0_v + 32'(i % C_H) * dx_v;
    endfunction
    function automatic logic [31:0] m_cy(input int i);
        return y0_v + 32'(i / C_H) * dy_v;
    endfunction
    function automatic logic m_found(input int rule, input logic [31:0] cx, input logic [31:0] cy);
        if (rule == 0) return (cx == x0_v + dx_v);
        return ^(cx ^ cy);
    endfunction

    // Drives one frame; a pixel index of -1 disables the corresponding disturbance
    task automatic run_frame(input int rule, input int busy_pix, input int stall_pix,
                             input int stall_cyc, input int spur_pix, input int abort_pix,
                             input bit rnd);
        int lat, hold, stall, dly;
        bit got;
        logic [31:0] gcx, gcy;
        logic exp_d;
        logic [C_AW-1:0] ea;
        @(negedge clk);
        bus.x0 = x0_v; bus.y0 = y0_v; bus.dx = dx_v; bus.dy = dy_v; bus.max_iter = mi_v;
        bus.start = 1'b1;
        if (busy_pix == 0) bus.frac_busy = 1'b1;
        for (int p = 0; p < C_PIX; p++) begin
            hold = (p == busy_pix) ? 3 : 0;
            got = 1'b0;
            lat = 0;
            for (int k = 1; k <= 40 && !got; k++) begin
                @(negedge clk);
                bus.start = 1'b0; bus.pix_ready = 1'b0; bus.frac_done_tick = 1'b0;
                if (k == 1) begin
                    bus.x0 = $urandom; bus.y0 = $urandom; bus.dx = $urandom; bus.dy = $urandom;
                    bus.max_iter = 16'($urandom);
                end
                if (k == hold + 1) bus.frac_busy = 1'b0;
                if (bus.frac_go === 1'b1) begin
                    got = 1'b1;
                    lat = k;
                end else if (p == spur_pix && k == 1) begin
                    bus.start = 1'b1; bus.frac_done_tick = 1'b1; bus.frac_found = 1'b1;
                end
            end
            n_cmp++;
            if (!got || lat != 2 + hold) begin
                n_bad++;
                $display("FAIL go_latency pix %0d: got %0d cycles, want %0d", p, lat, 2 + hold);
                if (!got) return;
            end
            n_cmp++;
            if (bus.frac_cx !== m_cx(p) || bus.frac_cy !== m_cy(p) || bus.frac_max_iter !== mi_v) begin
                n_bad++;
                $display("FAIL coord pix %0d: got cx=%h cy=%h mi=%h, want cx=%h cy=%h mi=%h",
                         p, bus.frac_cx, bus.frac_cy, bus.frac_max_iter, m_cx(p), m_cy(p), mi_v);
            end
            gcx = bus.frac_cx;
            gcy = bus.frac_cy;
            dly = rnd ? int'($urandom_range(0, 3)) : 1;
            @(negedge clk);
            n_cmp++;
            if (bus.frac_go !== 1'b0) begin
                n_bad++;
                $display("FAIL go_width pix %0d: got frac_go=%b, want 0", p, bus.frac_go);
            end
            repeat (dly) @(negedge clk);
            bus.frac_found = m_found(rule, gcx, gcy);
            bus.frac_done_tick = 1'b1;
            @(negedge clk);
            bus.frac_done_tick = 1'b0;
            bus.frac_found = 1'($urandom);
            exp_d = m_found(rule, m_cx(p), m_cy(p));
            ea = p[C_AW-1:0];
            n_cmp++;
            if (bus.pix_valid !== 1'b1 || bus.pix_addr !== ea || bus.pix_data !== exp_d ||
                bus.frame_done !== 1'b0 || bus.busy !== 1'b1) begin
                n_bad++;
                $display("FAIL pixel %0d: got v=%b a=%0d d=%b fd=%b busy=%b, want v=1 a=%0d d=%b fd=0 busy=1",
                         p, bus.pix_valid, bus.pix_addr, bus.pix_data, bus.frame_done, bus.busy, ea, exp_d);
            end
            if (p == abort_pix) begin
                rst_n = 1'b0;
                #1;
                n_cmp++;
                if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0 || bus.frac_go !== 1'b0 ||
                    bus.pix_valid !== 1'b0 || bus.pix_data !== 1'b0 || bus.pix_addr !== '0 ||
                    bus.frac_cx !== '0 || bus.frac_cy !== '0 || bus.frac_max_iter !== '0) begin
                    n_bad++;
                    $display("FAIL async_reset: got busy=%b v=%b d=%b a=%0d cx=%h cy=%h mi=%h, want all 0",
                             bus.busy, bus.pix_valid, bus.pix_data, bus.pix_addr,
                             bus.frac_cx, bus.frac_cy, bus.frac_max_iter);
                end
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            stall = (p == stall_pix) ? stall_cyc : (rnd ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                n_cmp++;
                if (bus.pix_valid !== 1'b1 || bus.pix_addr !== ea || bus.pix_data !== exp_d ||
                    bus.frac_go !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stall_hold pix %0d cyc %0d: got v=%b a=%0d d=%b go=%b, want v=1 a=%0d d=%b go=0",
                             p, s, bus.pix_valid, bus.pix_addr, bus.pix_data, bus.frac_go, ea, exp_d);
                end
            end
            bus.pix_ready = 1'b1;
            if (p + 1 == busy_pix) bus.frac_busy = 1'b1;
        end
        @(negedge clk);
        bus.pix_ready = 1'b0;
        n_cmp++;
        if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0 || bus.pix_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_done: got fd=%b busy=%b v=%b, want fd=1 busy=0 v=0",
                     bus.frame_done, bus.busy, bus.pix_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL done_width: got fd=%b, want 0", bus.frame_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0 || bus.frac_go !== 1'b0 ||
            bus.pix_valid !== 1'b0 || bus.pix_data !== 1'b0 || bus.pix_addr !== '0 ||
            bus.frac_cx !== '0 || bus.frac_cy !== '0 || bus.frac_max_iter !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got busy=%b v=%b a=%0d cx=%h cy=%h, want all 0",
                     bus.busy, bus.pix_valid, bus.pix_addr, bus.frac_cx, bus.frac_cy);
        end
`ifdef FRAC_DISPATCH_WDOG_EN
        n_cmp++;
        if (bus.wdog_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_wdog_err: got %b, want 0", bus.wdog_err);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        x0_v = 32'hE000_0000; dx_v = 32'h0800_0000; y0_v = 32'h0; dy_v = 32'h1000_0000;
        mi_v = 16'd100;
        run_frame(0, -1, -1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_ready_stall();
        run_frame(0, -1, 3, 5, -1, -1, 1'b0);
    endtask

    task automatic test_busy_hold();
        run_frame(0, 2, -1, 0, -1, -1, 1'b0);
        run_frame(0, 0, -1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_spurious();
        run_frame(0, -1, -1, 0, 4, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_frame(0, -1, -1, 0, -1, 5, 1'b0);
        run_frame(0, -1, -1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            x0_v = $urandom; y0_v = $urandom; dx_v = $urandom; dy_v = $urandom;
            mi_v = 16'($urandom);
            run_frame(1, int'($urandom_range(0, C_PIX)) - 1, int'($urandom_range(0, C_PIX - 1)),
                      int'($urandom_range(1, 4)), int'($urandom_range(0, C_PIX - 1)), -1, 1'b1);
        end
    endtask

`ifdef FRAC_DISPATCH_WDOG_EN
    task automatic test_wdog();
        int c;
        bit got;
        @(negedge clk);
        bus.x0 = x0_v; bus.y0 = y0_v; bus.dx = dx_v; bus.dy = dy_v; bus.max_iter = mi_v;
        bus.start = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.frac_go === 1'b1) got = 1'b1;
        end
        c = 0;
        while (got && bus.pix_valid !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (!got || c != C_WDOG + 1 || bus.pix_data !== 1'b0 || bus.wdog_err !== 1'b1) begin
            n_bad++;
            $display("FAIL wdog_timeout: got go=%b cycles=%0d d=%b err=%b, want go=1 cycles=%0d d=0 err=1",
                     got, c, bus.pix_data, bus.wdog_err, C_WDOG + 1);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.wdog_err !== 1'b0) begin
            n_bad++;
            $display("FAIL wdog_clear: got err=%b, want 0", bus.wdog_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        bus.start = 1'b0; bus.x0 = '0; bus.y0 = '0; bus.dx = '0; bus.dy = '0; bus.max_iter = '0;
        bus.frac_busy = 1'b0; bus.frac_done_tick = 1'b0; bus.frac_found = 1'b0; bus.pix_ready = 1'b0;
        test_reset();
        test_basic();
        test_ready_stall();
        test_busy_hold();
        test_spurious();
        test_reset_mid();
        test_random();
`ifdef FRAC_DISPATCH_WDOG_EN
        test_wdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/frac_pixel_dispatch.md
# frac_pixel_dispatch

Initiator side of the fractal engine handshake: sweeps a rectangular pixel window, computes each pixel's complex coordinate (cx, cy) by fixed-point stepping, launches one fractal evaluation per pixel and collects its result. Each result is written out through a valid/ready pixel-write port to the frame-buffer writer. One instance drives exactly one fractal core.

## Interface
Parameters:
- N, 32: coordinate width, signed fixed point, M integer bits.
- M, 4: integer bits, so F = N-M fractional bits.
- H_RES, 640: pixels per row.
- V_RES, 480: rows per frame.
- AW, 19: pixel address width; must satisfy 2^AW >= H_RES*V_RES.
- WDOG_CYC, 65535: watchdog limit in cycles. Used only with the watchdog macro.

Ports:
- frac_clk, in, 1: sole clock.
- frac_rst_n, in, 1: reset, asynchronous assert, active-low.
- start, in, 1: one-cycle request to render a frame.
- x0 / y0, in, N each: coordinate of pixel (0,0), two's complement.
- dx / dy, in, N each: per-column and per-row step, signed.
- max_iter, in, 16: iteration limit passed to the core.
- busy, out, 1: frame in progress.
- frame_done, out, 1: one-cycle pulse after the last pixel write is accepted.
- frac_cx / frac_cy, out, N each: coordinate sent to the core.
- frac_max_iter, out, 16: iteration limit sent to the core.
- frac_go, out, 1: one-cycle launch pulse to the core.
- frac_busy, in, 1: core busy.
- frac_done_tick, in, 1: core result strobe.
- frac_found, in, 1: core result; 1 means the point did not diverge.
- pix_addr, out, AW: linear address, row*H_RES+col.
- pix_data, out, 1: pixel value, equal to the found bit.
- pix_valid, out, 1: write request.
- pix_ready, in, 1: the write is accepted on any cycle where pix_valid and pix_ready are both 1.
- wdog_err, out, 1: sticky timeout flag. Exists only with FRAC_DISPATCH_WDOG_EN.

## Operation
States: IDLE, ISSUE, WAIT, WRITE.

- IDLE:
  - On start: latch x0, y0, dx, dy and max_iter.
  - Set cx=x0, cy=y0, col=0, row=0, pix_addr=0, busy=1.
  - Go to ISSUE.
  - start is ignored in every state other than IDLE.
- ISSUE:
  - While frac_busy=1, hold in ISSUE.
  - Otherwise pulse frac_go for exactly one cycle and go to WAIT.
  - frac_cx, frac_cy and frac_max_iter are registered and stay stable from ISSUE entry until the next ISSUE.
- WAIT:
  - On frac_done_tick, capture frac_found into pix_data and go to WRITE.
  - frac_found is sampled in the same cycle as the strobe.
- WRITE:
  - Hold pix_valid=1, with pix_addr and pix_data stable, until pix_ready.
  - On acceptance, if col==H_RES-1 and row==V_RES-1: pulse frame_done, clear busy, go to IDLE.
  - Otherwise advance the position and go to ISSUE.
- Position advance:
  - col<H_RES-1: col+1, cx+=dx.
  - Otherwise: col=0, cx=x0 (latched), row+1, cy+=dy.
  - pix_addr always increments by 1; it is a counter, not a multiplier.
- Arithmetic: cx and cy additions are N-bit two's complement and wrap modulo 2^N. No saturation.
- frac_done_tick outside WAIT is ignored.

## Timing
- Reset values: busy=0, frame_done=0, frac_go=0, pix_valid=0, pix_data=0, pix_addr=0, frac_cx=0, frac_cy=0, frac_max_iter=0, wdog_err=0. State is IDLE.
- Reset mid-frame aborts immediately. No partial-pixel write completes after reset.
- start to first frac_go: 2 cycles (IDLE→ISSUE edge, then pulse), assuming frac_busy=0.
- frac_done_tick to pix_valid: 1 cycle.
- Pixel accept to next frac_go: 2 cycles minimum.
- Per-pixel overhead excluding core compute: 4 cycles plus pix_ready stall.
- frame_done asserts in the cycle after the final accept. busy falls on the same edge.

## Configuration
- FRAC_DISPATCH_WDOG_EN defined:
  - A counter runs in WAIT, cleared on WAIT entry.
  - If it reaches WDOG_CYC without frac_done_tick: set pix_data=0, set wdog_err=1 (sticky until reset), go to WRITE.
  - The next ISSUE still waits for frac_busy=0.
- Not defined:
  - WAIT waits indefinitely.
  - wdog_err port and counter are absent.

## Test plan
- H_RES=4, V_RES=2, x0=0xE0000000, dx=0x08000000, y0=0, dy=0x10000000; core model returns found=1 iff frac_cx==frac_cx of col 1. Required: 8 writes, addresses 0..7, data 0,1,0,0,0,1,0,0. Row 1 frac_cy=0x10000000. One frame_done after addr 7.
- pix_ready held low for 5 cycles on pixel 3: pix_valid, pix_addr=3 and pix_data remain stable. No frac_go is issued until the write is accepted.
- frac_busy held high for 3 cycles when ISSUE is entered: frac_go is delayed until frac_busy falls, and is exactly 1 cycle wide.
- start pulsed mid-frame, and a spurious frac_done_tick in ISSUE: both are ignored; address sequence and frame_done count are unchanged.
- frac_rst_n low at pixel 5 of 8, then start: outputs at reset values asynchronously. New frame begins at pix_addr 0 with frac_cx=x0.
- With FRAC_DISPATCH_WDOG_EN and WDOG_CYC=10, the core never strobes: pixel written with data 0 eleven cycles after WAIT entry, and wdog_err=1.
